// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, control-word and state definitions for the ALU control sequencer.
// Control words are written with Ctrl5 as the leftmost bit, matching ctrl[5:0].
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_SLA = 4'h9;
  localparam logic [3:0] OP_SLL = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_SRA = 4'hC;
  localparam logic [3:0] OP_SRL = 4'hD;
  localparam logic [3:0] OP_ROR = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;

  localparam logic [5:0] CTRL_ADD = 6'b010010;
  localparam logic [5:0] CTRL_SUB = 6'b010001;
  localparam logic [5:0] CTRL_OR  = 6'b001010;
  localparam logic [5:0] CTRL_NOT = 6'b001100;
  localparam logic [5:0] CTRL_XOR = 6'b001110;
  localparam logic [5:0] CTRL_AND = 6'b000110;
  localparam logic [5:0] CTRL_MOV = 6'b000000;
  localparam logic [5:0] CTRL_INC = 6'b011011;
  localparam logic [5:0] CTRL_DEC = 6'b011000;
  localparam logic [5:0] CTRL_SLA = 6'b100100;
  localparam logic [5:0] CTRL_SLL = 6'b100000;
  localparam logic [5:0] CTRL_ROL = 6'b100010;
  localparam logic [5:0] CTRL_SRA = 6'b101100;
  localparam logic [5:0] CTRL_SRL = 6'b101000;
  localparam logic [5:0] CTRL_ROR = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctrl_encode.sv
// Combinational opcode to decoder control-word encoder; flags the one illegal opcode.
module alu_ctrl_encode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic [5:0] ctrl,
  output logic       legal
);

  always_comb begin
    ctrl  = CTRL_MOV;
    legal = 1'b1;
    case (op)
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_OR:   ctrl = CTRL_OR;
      OP_NOT:  ctrl = CTRL_NOT;
      OP_XOR:  ctrl = CTRL_XOR;
      OP_AND:  ctrl = CTRL_AND;
      OP_MOV:  ctrl = CTRL_MOV;
      OP_INC:  ctrl = CTRL_INC;
      OP_DEC:  ctrl = CTRL_DEC;
      OP_SLA:  ctrl = CTRL_SLA;
      OP_SLL:  ctrl = CTRL_SLL;
      OP_ROL:  ctrl = CTRL_ROL;
      OP_SRA:  ctrl = CTRL_SRA;
      OP_SRL:  ctrl = CTRL_SRL;
      OP_ROR:  ctrl = CTRL_ROR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Request/response sequencer: registers the ALU control word, holds it for SETUP_CYCLES,
// pulses alu_strobe once, captures the carry out and presents it as a response.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic       req_cin,
  output logic [5:0] ctrl,
  output logic       c_flag,
  output logic       alu_strobe,
  input  logic       alu_cout,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_cout,
  output logic       resp_err,
  output logic       busy
);

  localparam logic [3:0] CNT_LOAD = 4'(SETUP_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [5:0] ctrl_reg, ctrl_next;
  logic       c_flag_reg, c_flag_next;
  logic       resp_cout_reg, resp_cout_next;
  logic       resp_err_reg, resp_err_next;

  logic [5:0] enc_ctrl;
  logic       enc_legal;

  alu_ctrl_encode u_encode (
    .op    (req_op),
    .ctrl  (enc_ctrl),
    .legal (enc_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      ctrl_reg      <= CTRL_MOV;
      c_flag_reg    <= 1'b0;
      resp_cout_reg <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ctrl_reg      <= ctrl_next;
      c_flag_reg    <= c_flag_next;
      resp_cout_reg <= resp_cout_next;
      resp_err_reg  <= resp_err_next;
    end
  end

  // ctrl/c_flag default to holding so the decoders see no change outside a legal accept.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ctrl_next      = ctrl_reg;
    c_flag_next    = c_flag_reg;
    resp_cout_next = resp_cout_reg;
    resp_err_next  = resp_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (enc_legal) begin
            ctrl_next     = enc_ctrl;
            c_flag_next   = req_cin;
            cnt_next      = CNT_LOAD;
            resp_err_next = 1'b0;
            state_next    = ST_SETUP;
          end else begin
            resp_err_next  = 1'b1;
            resp_cout_next = 1'b0;
            state_next     = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_reg == 4'd0) state_next = ST_STROBE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_STROBE: begin
        resp_cout_next = alu_cout;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = !rst && (state_reg == ST_IDLE);
  assign alu_strobe = (state_reg == ST_STROBE);
  assign resp_valid = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);
  assign ctrl       = ctrl_reg;
  assign c_flag     = c_flag_reg;
  assign resp_cout  = resp_cout_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed plus randomized bench for alu_ctrl_sequencer, checked against a cycle-count
// reference built from the opcode table and the accept-relative latency rules.
module tb_alu_ctrl_sequencer;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic       req_cin;
  logic [5:0] ctrl;
  logic       c_flag;
  logic       alu_strobe;
  logic       alu_cout;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_cout;
  logic       resp_err;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [5:0] word_tbl [16];
  logic [5:0] last_ctrl;
  logic       last_cflag;
  int         last_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_ctrl_sequencer #(.SETUP_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_cin    (req_cin),
    .ctrl       (ctrl),
    .c_flag     (c_flag),
    .alu_strobe (alu_strobe),
    .alu_cout   (alu_cout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cout  (resp_cout),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b, expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_word(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b, expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE back to IDLE; hold = cycles of resp_ready=0 in DONE.
  task automatic do_op(input logic [3:0] op, input logic cin, input logic cout,
                       input int hold, input bit chk_spacing);
    logic [5:0] w;
    logic       legal;
    int         acc;
    legal = (op != 4'hF);
    w     = legal ? word_tbl[op] : last_ctrl;
    check_bit("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    req_cin   = cin;
    step();
    acc       = cyc;
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_cin   = 1'($urandom);
    if (chk_spacing) check_int("accept_spacing", acc - last_acc, SC + 3);
    last_acc = acc;
    if (legal) begin
      last_ctrl  = w;
      last_cflag = cin;
      for (int k = 1; k <= SC + 1; k++) begin
        check_word("ctrl_setup", ctrl, w);
        check_bit("c_flag_setup", c_flag, cin);
        check_bit("strobe_timing", alu_strobe, k == SC + 1);
        check_bit("resp_valid_early", resp_valid, 1'b0);
        alu_cout = (k == SC + 1) ? cout : 1'($urandom);
        step();
      end
      alu_cout = ~cout;
    end
    check_bit("resp_valid", resp_valid, 1'b1);
    check_bit("resp_err", resp_err, !legal);
    check_bit("resp_cout", resp_cout, legal ? cout : 1'b0);
    check_word("ctrl_done", ctrl, last_ctrl);
    check_bit("c_flag_done", c_flag, last_cflag);
    check_bit("strobe_in_done", alu_strobe, 1'b0);
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      req_valid  = 1'($urandom);
      req_op     = 4'($urandom);
      step();
      check_bit("bp_req_ready", req_ready, 1'b0);
      check_bit("bp_resp_valid", resp_valid, 1'b1);
      check_bit("bp_resp_cout", resp_cout, legal ? cout : 1'b0);
      check_word("bp_ctrl", ctrl, last_ctrl);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    check_bit("back_idle", busy, 1'b0);
    $display("op=%h cin=%b cout=%b hold=%0d accepted@%0d ctrl=%b err=%b", op, cin, cout,
             hold, acc, ctrl, resp_err);
  endtask

  initial begin
    word_tbl[0]  = 6'b010010; word_tbl[1]  = 6'b010001; word_tbl[2]  = 6'b001010;
    word_tbl[3]  = 6'b001100; word_tbl[4]  = 6'b001110; word_tbl[5]  = 6'b000110;
    word_tbl[6]  = 6'b000000; word_tbl[7]  = 6'b011011; word_tbl[8]  = 6'b011000;
    word_tbl[9]  = 6'b100100; word_tbl[10] = 6'b100000; word_tbl[11] = 6'b100010;
    word_tbl[12] = 6'b101100; word_tbl[13] = 6'b101000; word_tbl[14] = 6'b101010;
    word_tbl[15] = 6'b000000;
    last_acc   = 0;
    last_ctrl  = 6'b000000;
    last_cflag = 1'b0;

    // Reset held with a request pending
    rst = 1'b1; req_valid = 1'b1; req_op = 4'h0; req_cin = 1'b1;
    alu_cout = 1'b0; resp_ready = 1'b1;
    #1;
    check_bit("rst_req_ready", req_ready, 1'b0);
    step();
    step();
    check_bit("rst_req_ready2", req_ready, 1'b0);
    check_word("rst_ctrl", ctrl, 6'b000000);
    check_bit("rst_c_flag", c_flag, 1'b0);
    check_bit("rst_strobe", alu_strobe, 1'b0);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    rst = 1'b0; req_valid = 1'b0;
    step();
    check_bit("post_rst_busy", busy, 1'b0);
    $display("reset done ctrl=%b", ctrl);

    // ADD with cin=1, carry out 1
    do_op(4'h0, 1'b1, 1'b1, 0, 1'b0);

    // Back-to-back sweep of all legal opcodes
    for (int op = 0; op < 15; op++)
      do_op(4'(op), 1'($urandom), 1'($urandom), 0, op != 0);

    // Illegal opcode keeps the previous word
    do_op(4'hF, 1'b1, 1'b0, 0, 1'b0);

    // SUB under 5 cycles of backpressure
    do_op(4'h1, 1'($urandom), 1'($urandom), 5, 1'b0);

    // ROR squashed by reset right after accept
    check_bit("ror_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = 4'hE; req_cin = 1'b1;
    step();
    req_valid = 1'b0;
    check_word("ror_ctrl", ctrl, 6'b101010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    last_ctrl = 6'b000000; last_cflag = 1'b0;
    check_word("squash_ctrl", ctrl, 6'b000000);
    check_bit("squash_c_flag", c_flag, 1'b0);
    check_bit("squash_busy", busy, 1'b0);
    check_bit("squash_req_ready", req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_bit("squash_strobe", alu_strobe, 1'b0);
      check_bit("squash_resp_valid", resp_valid, 1'b0);
      step();
    end
    $display("reset squash of ROR done ctrl=%b", ctrl);

    // Randomized ops with random backpressure
    for (int n = 0; n < 30; n++)
      do_op(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
